// File: rtl/frame_buffer_arbiter.sv
// ============================================================================
// frame_buffer_arbiter
//   Shares a single-port frame-buffer BRAM between VGA scan-out reads (strict
//   priority, fixed 3-clk latency) and FIFO-buffered camera writes.
//   Optional: define FB_DROP_COUNT_EN to add a saturating drop_count output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_buffer_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    input  logic                          wr_req,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    input  logic                          wr_flush,
    input  logic                          clr_ovf,
    output logic                          overflow,
`ifdef FB_DROP_COUNT_EN
    output logic [15:0]                   drop_count,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] C_DEPTH = LVL_W'(FIFO_DEPTH);

    logic [ADDR_W-1:0] r_q_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_count;
    logic              r_wr_ready;
    logic              r_ovf;
    logic              r_rd_s1;
    logic              r_rd_s2;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [LVL_W-1:0]  w_count_nxt;

    // wr_ready is a registered copy of !full, so a drop is judged from it.
    assign w_empty = (r_count == '0);
    assign w_push  = wr_req &  r_wr_ready & ~wr_flush;
    assign w_drop  = wr_req & ~r_wr_ready & ~wr_flush;
    assign w_pop   = ~rd_req & ~w_empty & ~wr_flush;

    always_comb begin
        w_count_nxt = r_count;
        if (wr_flush) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wptr] <= wr_addr;
            r_q_data[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_wr_ready <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (wr_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
            end
            r_count    <= w_count_nxt;
            r_wr_ready <= (w_count_nxt != C_DEPTH);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Issue stage: reads win, otherwise drain one queued write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (rd_req) begin
            r_mem_en   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= rd_addr;
        end else if (w_pop) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_q_addr[r_rptr];
            r_mem_wdata <= r_q_data[r_rptr];
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_s1    <= 1'b0;
            r_rd_s2    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_s1    <= rd_req;
            r_rd_s2    <= r_rd_s1;
            r_rd_valid <= r_rd_s2;
            if (r_rd_s2) r_rd_data <= mem_rdata;
        end
    end

`ifdef FB_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= '0;
        end else if (w_drop) begin
            if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
        end else if (clr_ovf) begin
            r_drop_count <= '0;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign wr_ready   = r_wr_ready;
    assign overflow   = r_ovf;
    assign fifo_level = r_count;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_frame_buffer_arbiter.sv
// ============================================================================
// tb_frame_buffer_arbiter
//   Directed and randomized stimulus against a queue-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_frame_buffer_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 12;
    localparam int DEPTH = 4;
    localparam int MSIZE = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          wr_flush = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          overflow;
    logic [2:0]    fifo_level;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef FB_DROP_COUNT_EN
    logic [15:0]   drop_count;
`endif

    frame_buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .wr_flush   (wr_flush),
        .clr_ovf    (clr_ovf),
        .overflow   (overflow),
`ifdef FB_DROP_COUNT_EN
        .drop_count (drop_count),
`endif
        .fifo_level (fifo_level),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // BRAM with 1-clk read latency.
    logic [DW-1:0] bram [0:MSIZE-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= bram[mem_addr];
        end
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } rd_t;

    wr_t           q[$];
    rd_t           pend[$];
    logic [DW-1:0] ref_mem [0:MSIZE-1];
    int            cyc;
    bit            m_ready;
    bit            m_ovf;
    int            m_dcnt;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            n_checks;
    int            n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    endtask

    task automatic chk_reset_state();
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_fifo_level", 32'(fifo_level), 0);
`ifdef FB_DROP_COUNT_EN
        chk("rst_drop_count", 32'(drop_count), 0);
`endif
    endtask

    // Asserted away from the clock edge to exercise the asynchronous path.
    task automatic apply_reset();
        rd_req = 0; wr_req = 0; wr_flush = 0; clr_ovf = 0;
        #2 reset_n = 1'b0;
        #1 chk_reset_state();
        q.delete(); pend.delete();
        m_ready = 0; m_ovf = 0; m_dcnt = 0;
        m_rdata = '0; m_addr = '0; m_wdata = '0;
        repeat (2) @(posedge clk);
        #1 chk_reset_state();
        reset_n = 1'b1;
    endtask

    // One clock: predict from the rules, advance, then compare.
    task automatic tick();
        bit  drop, push, exp_en, exp_we, exp_v;
        wr_t h;
        rd_t r;
        drop   = wr_req && !m_ready && !wr_flush;
        push   = wr_req &&  m_ready && !wr_flush;
        exp_en = 0;
        exp_we = 0;
        if (rd_req) begin
            exp_en = 1;
            m_addr = rd_addr;
            r.due  = cyc + 3;
            r.d    = ref_mem[rd_addr];
            pend.push_back(r);
        end else if (q.size() > 0 && !wr_flush) begin
            h = q.pop_front();
            exp_en = 1;
            exp_we = 1;
            m_addr = h.a;
            m_wdata = h.d;
            ref_mem[h.a] = h.d;
        end
        if (push) begin
            h.a = wr_addr;
            h.d = wr_data;
            q.push_back(h);
        end
        if (wr_flush) q.delete();
        if (drop) begin
            m_ovf = 1;
            if (m_dcnt < 65535) m_dcnt++;
        end else if (clr_ovf) begin
            m_ovf = 0;
            m_dcnt = 0;
        end
        m_ready = (q.size() < DEPTH);

        @(posedge clk);
        #1;
        cyc++;
        exp_v = (pend.size() > 0) && (pend[0].due == cyc);
        if (exp_v) begin
            r = pend.pop_front();
            m_rdata = r.d;
        end
        chk("mem_en", 32'(mem_en), 32'(exp_en));
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        chk("rd_valid", 32'(rd_valid), 32'(exp_v));
        chk("rd_data", 32'(rd_data), 32'(m_rdata));
        chk("wr_ready", 32'(wr_ready), 32'(m_ready));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("fifo_level", 32'(fifo_level), q.size());
`ifdef FB_DROP_COUNT_EN
        chk("drop_count", 32'(drop_count), m_dcnt);
`endif
    endtask

    task automatic drive(input bit rr, input int ra, input bit wq, input int wa, input int wd,
                         input bit fl, input bit co);
        rd_req = rr; rd_addr = AW'(ra);
        wr_req = wq; wr_addr = AW'(wa); wr_data = DW'(wd);
        wr_flush = fl; clr_ovf = co;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        for (int i = 0; i < MSIZE; i++) begin
            bram[i]    = DW'(i * 7);
            ref_mem[i] = DW'(i * 7);
        end
        bram[17'h10]    = 12'hABC;
        ref_mem[17'h10] = 12'hABC;

        apply_reset();

        // Single read after reset release.
        drive(1, 'h10, 0, 0, 0, 0, 0);
        idle(4);

        // Four writes with no reads, drained in order.
        for (int i = 1; i <= 4; i++) drive(0, 0, 1, i, 'h111 * i, 0, 0);
        idle(4);

        // Reads held 10 clk while 5 writes arrive: fifth dropped.
        for (int i = 0; i < 10; i++)
            drive(1, i, (i < 5), 'h20 + i, 'h500 + i, 0, 0);
        idle(6);
        drive(1, 'h22, 0, 0, 0, 0, 0);
        idle(4);

        // Flush with level 3 and a concurrent write.
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, i, 1, 'h30 + i, 'h600 + i, 0, 0);
        drive(0, 0, 1, 'h33, 'h633, 1, 0);
        idle(3);

        // Reset mid-read with level 2.
        drive(1, 1, 1, 'h40, 'h700, 0, 0);
        drive(1, 2, 1, 'h41, 'h701, 0, 0);
        drive(1, 'h10, 0, 0, 0, 0, 0);
        apply_reset();
        idle(4);

        // Drop and clr_ovf in the same cycle, then clr_ovf alone.
        for (int i = 0; i < 4; i++) drive(1, i, 1, 'h50 + i, 'h800 + i, 0, 0);
        drive(1, 5, 1, 'h54, 'h804, 0, 1);
        drive(1, 6, 0, 0, 0, 0, 1);
        idle(6);

        // Randomized traffic on a small address window.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 100) < 60, $urandom % 32,
                  ($urandom % 100) < 50, $urandom % 32, $urandom,
                  ($urandom % 100) < 4, ($urandom % 100) < 8);
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frame_buffer_arbiter.md
Name: frame_buffer_arbiter

Overview:
- Shares one single-port frame-buffer BRAM between the camera capture path (writer) and the VGA scan-out path (reader).
- VGA reads have strict priority and a fixed latency, so scan-out never stalls.
- Camera writes are buffered in a small FIFO and drained into idle memory cycles.
- Sits between the OV7670 capture logic, the VGA pixel fetch, and the frame-buffer BRAM, all in the system clk domain.

Parameters:
- ADDR_W, 17, frame-buffer address width (320x240 = 76800 pixels).
- DATA_W, 12, pixel width (RGB444).
- FIFO_DEPTH, 4, write FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rd_req  in  1  VGA read request, one pixel per asserted cycle
- rd_addr  in  ADDR_W  read address, sampled with rd_req
- rd_data  out  DATA_W  read pixel
- rd_valid  out  1  one-cycle strobe; rd_data is valid while high
- wr_req  in  1  camera write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write pixel
- wr_ready  out  1  FIFO not full
- wr_flush  in  1  synchronous FIFO clear, driven from camera VSYNC
- clr_ovf  in  1  clears the overflow flag
- overflow  out  1  sticky flag: a write was dropped
- fifo_level  out  clog2(FIFO_DEPTH)+1  number of queued writes
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  DATA_W  BRAM write data
- mem_rdata  in  DATA_W  BRAM read data; BRAM read latency is 1 clk

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0, FIFO empty, fifo_level=0, overflow=0, in-flight reads discarded. wr_ready becomes 1 on the first clk after reset release.
- Issue stage: all mem_* outputs are registered, and the source is decided each clk edge.
  1. rd_req=1: issue a read. mem_en=1, mem_we=0, mem_addr=rd_addr.
  2. Otherwise, FIFO not empty: pop the head entry and issue a write. mem_en=1, mem_we=1, mem_addr/mem_wdata from the head.
  3. Otherwise: mem_en=0, mem_we=0; mem_addr/mem_wdata hold their previous values.
- Read pipeline: rd_req sampled at edge N, mem_en during N+1, mem_rdata valid during N+2, rd_data registered, rd_valid=1 during N+3 only.
  - Latency is exactly 3 clk, independent of write traffic.
  - Back-to-back rd_req is supported at 1 read/clk.
  - rd_data holds its value when rd_valid=0.
- Write FIFO:
  - wr_ready = !full, from registered state.
  - Push when wr_req && wr_ready.
  - wr_req while full: entry dropped and overflow set. This holds even if a pop occurs in the same cycle; no same-cycle refill of a full FIFO.
  - Push and pop in the same cycle: level unchanged; order preserved (FIFO).
  - Pointers wrap modulo FIFO_DEPTH.
- wr_flush=1: FIFO emptied at the edge and no pop is issued that cycle.
  - Flush has priority over push and pop; a wr_req in the same cycle is discarded without setting overflow.
  - A write already issued to mem_* completes normally.
- overflow: set on any drop, cleared by clr_ovf. If both occur in the same cycle, set wins.
- Starvation: writes are delayed only while rd_req is continuously high. The upstream guarantees at least 1 idle cycle per 4 (25 MHz pixel pulse at 100 MHz clk), so FIFO_DEPTH=4 cannot overflow at camera rate.

Optional Feature:
- Macro FB_DROP_COUNT_EN.
- When defined:
  - Adds output drop_count (16 bits): saturating count of dropped writes, holding at 16'hFFFF.
  - Cleared together with overflow by clr_ovf; increment wins if simultaneous.
  - Flush discards are not counted.
  - Reset value 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset release, single rd_req at addr 0x00010, BRAM model returns 0xABC -> rd_valid high exactly 3 clk later, rd_data=0xABC; all outputs 0 during reset.
- Writes 0x111..0x444 to addr 1..4 with no reads -> mem_we pulses in order, addresses 1,2,3,4, fifo_level returns to 0, overflow=0.
- rd_req held high for 10 clk while 5 writes arrive -> FIFO fills to 4, wr_ready=0, 5th write dropped, overflow=1 (drop_count=1 if FB_DROP_COUNT_EN), read latency unchanged; after rd_req drops, 4 writes drain in order.
- wr_flush asserted while fifo_level=3, together with wr_req -> fifo_level=0 next clk, no memory write issued, overflow unchanged.
- reset_n pulled low mid-read (between rd_req and rd_valid) and with fifo_level=2 -> rd_valid never asserts, mem_en=0, fifo_level=0 immediately (asynchronous).
- clr_ovf and a drop in the same cycle -> overflow stays 1; next clr_ovf alone clears it to 0.
